// File: rtl/video_compositor.sv
// video_compositor: pipelined base-image select plus NUM_LAYERS overlay stack.
// Configuration (base mode, layer enables) is latched on new_frame_in so a
// frame never mixes two configurations. Sync/position are delayed to match.
// Optional build macro: ALPHA_BLEND_EN makes layer 0 a 50 % translucent blend.
//
// Stream semantics: there is no valid/ready handshake and no backpressure.
// One pixel is accepted every cycle and one is produced every cycle,
// NUM_LAYERS+1 cycles later. active_in marks visible pixels; invisible
// pixels are driven out as 0.
module video_compositor #(
  parameter int NUM_LAYERS = 4,
  parameter int COLOR_W    = 8
) (
  input  logic                             clk_in,
  input  logic                             rst_in,
  input  logic [1:0]                       bg_sel_req_in,
  input  logic [NUM_LAYERS-1:0]            layer_en_req_in,
  input  logic                             new_frame_in,
  input  logic [3*COLOR_W-1:0]             camera_pixel_in,
  input  logic [COLOR_W-1:0]               camera_y_in,
  input  logic [COLOR_W-1:0]               channel_in,
  input  logic                             thresholded_pixel_in,
  input  logic [NUM_LAYERS*3*COLOR_W-1:0]  layer_pixel_in,
  input  logic [NUM_LAYERS-1:0]            layer_valid_in,
  input  logic                             active_in,
  input  logic                             hsync_in,
  input  logic                             vsync_in,
  input  logic [10:0]                      hcount_in,
  input  logic [9:0]                       vcount_in,
  output logic [3*COLOR_W-1:0]             pixel_out,
  output logic                             active_out,
  output logic                             hsync_out,
  output logic                             vsync_out,
  output logic [10:0]                      hcount_out,
  output logic [9:0]                       vcount_out,
  output logic                             cfg_pending_out
);

  localparam int PW = 3 * COLOR_W;
  localparam int N  = NUM_LAYERS;
  // timing word: {active, hsync, vsync, hcount[10:0], vcount[9:0]}
  localparam int TW = 24;

  // Take the top COLOR_W bits of a byte (zero-extended when COLOR_W > 8).
  function automatic logic [COLOR_W-1:0] scale8(input logic [7:0] b);
    logic [COLOR_W+7:0] t;
    t = {b, {COLOR_W{1'b0}}};
    return t[COLOR_W+7 -: COLOR_W];
  endfunction

  localparam logic [PW-1:0] MARK_COLOR = {scale8(8'hFF), scale8(8'h77), scale8(8'hAA)};

`ifdef ALPHA_BLEND_EN
  // Per-channel 50 % mix; each half fits in COLOR_W-1 bits so no overflow.
  function automatic logic [PW-1:0] blend(input logic [PW-1:0] top,
                                          input logic [PW-1:0] below);
    logic [PW-1:0] r;
    r = '0;
    for (int c = 0; c < 3; c++) begin
      r[c*COLOR_W +: COLOR_W] = (top[c*COLOR_W +: COLOR_W] >> 1) +
                                (below[c*COLOR_W +: COLOR_W] >> 1);
    end
    return r;
  endfunction
`endif

  logic [1:0]    cfg_bg;
  logic [N-1:0]  cfg_en;
  logic [1:0]    eff_bg;
  logic [N-1:0]  eff_en;
  logic [PW-1:0] base_pix;
  logic [PW-1:0] pix_q     [0:N];
  logic [TW-1:0] tm_q      [0:N];
  logic [PW-1:0] stage_nxt [0:N-1];

  // The frame's first pixel sees the freshly requested configuration.
  assign eff_bg = new_frame_in ? bg_sel_req_in   : cfg_bg;
  assign eff_en = new_frame_in ? layer_en_req_in : cfg_en;

  // Latch configuration at frame start; flag requests that differ from it.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      cfg_bg          <= 2'b00;
      cfg_en          <= '0;
      cfg_pending_out <= 1'b0;
    end else begin
      cfg_bg          <= eff_bg;
      cfg_en          <= eff_en;
      cfg_pending_out <= (bg_sel_req_in != eff_bg) | (layer_en_req_in != eff_en);
    end
  end

  // Base image selection for stage 0.
  always_comb begin
    base_pix = camera_pixel_in;
    case (eff_bg)
      2'b00:   base_pix = camera_pixel_in;
      2'b01:   base_pix = {channel_in, channel_in, channel_in};
      2'b10:   base_pix = thresholded_pixel_in ? {PW{1'b1}} : {PW{1'b0}};
      default: base_pix = thresholded_pixel_in ? MARK_COLOR
                                               : {camera_y_in, camera_y_in, camera_y_in};
    endcase
  end

  // Main pixel and timing pipe: stage 0 registers the base, stages 1..N the overlays.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i <= N; i++) begin
        pix_q[i] <= '0;
        tm_q[i]  <= '0;
      end
    end else begin
      pix_q[0] <= base_pix;
      tm_q[0]  <= {active_in, hsync_in, vsync_in, hcount_in, vcount_in};
      for (int i = 1; i <= N; i++) begin
        pix_q[i] <= stage_nxt[i-1];
        tm_q[i]  <= tm_q[i-1];
      end
    end
  end

  // Per-layer delay line carries {enabled&valid, colour} alongside its pixel,
  // so a configuration change never tears pixels already in flight.
  for (genvar k = 0; k < N; k++) begin : g_layer
    logic [PW:0]   dl [0:k];
    logic          sel;
    logic [PW-1:0] lpix;

    // Shift layer k's selection/colour k+1 cycles to meet stage k's pixel.
    always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
        for (int i = 0; i <= k; i++) dl[i] <= '0;
      end else begin
        dl[0] <= {eff_en[k] & layer_valid_in[k], layer_pixel_in[k*PW +: PW]};
        for (int i = 1; i <= k; i++) dl[i] <= dl[i-1];
      end
    end

    assign {sel, lpix} = dl[k];

    if (k == 0) begin : g_bottom
`ifdef ALPHA_BLEND_EN
      assign stage_nxt[k] = sel ? blend(lpix, pix_q[k]) : pix_q[k];
`else
      assign stage_nxt[k] = sel ? lpix : pix_q[k];
`endif
    end else begin : g_upper
      assign stage_nxt[k] = sel ? lpix : pix_q[k];
    end
  end

  assign {active_out, hsync_out, vsync_out, hcount_out, vcount_out} = tm_q[N];
  assign pixel_out = active_out ? pix_q[N] : '0;

endmodule

// File: tb/tb_video_compositor.sv
// Self-checking bench for video_compositor (NUM_LAYERS=4, COLOR_W=8).
// A reference model pushes the expected output word for every driven pixel;
// a monitor pops and compares one word per clock.
module tb_video_compositor;

  localparam int N  = 4;
  localparam int PW = 24;
  localparam int L  = N + 1;
  localparam int EW = PW + 24;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // DUT inputs
  logic [1:0]      bg_req = '0;
  logic [N-1:0]    en_req = '0;
  logic            nf = 1'b0;
  logic [PW-1:0]   cam = '0;
  logic [7:0]      y = '0;
  logic [7:0]      ch = '0;
  logic            thr = 1'b0;
  logic [N*PW-1:0] lp = '0;
  logic [N-1:0]    lv = '0;
  logic            act = 1'b0;
  logic            hs = 1'b0;
  logic            vs = 1'b0;
  logic [10:0]     hc = '0;
  logic [9:0]      vc = '0;

  // DUT outputs
  logic [PW-1:0]   pix_o;
  logic            act_o, hs_o, vs_o, pend_o;
  logic [10:0]     hc_o;
  logic [9:0]      vc_o;

  video_compositor #(.NUM_LAYERS(N), .COLOR_W(8)) dut (
    .clk_in(clk), .rst_in(rst),
    .bg_sel_req_in(bg_req), .layer_en_req_in(en_req), .new_frame_in(nf),
    .camera_pixel_in(cam), .camera_y_in(y), .channel_in(ch),
    .thresholded_pixel_in(thr), .layer_pixel_in(lp), .layer_valid_in(lv),
    .active_in(act), .hsync_in(hs), .vsync_in(vs),
    .hcount_in(hc), .vcount_in(vc),
    .pixel_out(pix_o), .active_out(act_o), .hsync_out(hs_o), .vsync_out(vs_o),
    .hcount_out(hc_o), .vcount_out(vc_o), .cfg_pending_out(pend_o)
  );

  // scoreboard state
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] exp_w;
  logic          sb_en = 1'b0;
  logic          exp_pend = 1'b0;
  logic [1:0]    m_bg = '0;
  logic [N-1:0]  m_en = '0;
  int            vectors = 0;
  int            errors = 0;

  // monitor: one output word per clock, sampled 1 ns after the edge
  always @(posedge clk) begin
    #1;
    if (sb_en) begin
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_underflow: no expected word queued at %0t", $time);
      end else begin
        exp_w = exp_q.pop_front();
        vectors++;
        if ({pix_o, act_o, hs_o, vs_o, hc_o, vc_o} !== exp_w) begin
          errors++;
          $display("FAIL pipe_out at %0t: got pix=%h a=%b h=%b v=%b hc=%0d vc=%0d, expected pix=%h a=%b h=%b v=%b hc=%0d vc=%0d",
                   $time, pix_o, act_o, hs_o, vs_o, hc_o, vc_o,
                   exp_w[47:24], exp_w[23], exp_w[22], exp_w[21], exp_w[20:10], exp_w[9:0]);
        end
      end
    end
  end

  // Queue the zeros a freshly reset pipe emits before the first new pixel.
  task automatic sb_restart();
    exp_q.delete();
    for (int i = 0; i < L - 1; i++) exp_q.push_back('0);
    m_bg = '0;
    m_en = '0;
    sb_en = 1'b1;
  endtask

  // driver: model the current inputs, queue the expected word, clock once
  task automatic step();
    logic [1:0]    ebg;
    logic [N-1:0]  een;
    logic [PW-1:0] p;
    logic [PW-1:0] l;
    ebg = nf ? bg_req : m_bg;
    een = nf ? en_req : m_en;
    case (ebg)
      2'd0: p = cam;
      2'd1: p = {ch, ch, ch};
      2'd2: p = thr ? 24'hFFFFFF : 24'h000000;
      default: p = thr ? 24'hFF77AA : {y, y, y};
    endcase
    for (int k = 0; k < N; k++) begin
      if (een[k] && lv[k]) begin
        l = lp[k*PW +: PW];
`ifdef ALPHA_BLEND_EN
        if (k == 0) begin
          p = {(l[23:16] >> 1) + (p[23:16] >> 1),
               (l[15:8]  >> 1) + (p[15:8]  >> 1),
               (l[7:0]   >> 1) + (p[7:0]   >> 1)};
        end else begin
          p = l;
        end
`else
        p = l;
`endif
      end
    end
    if (!act) p = '0;
    exp_q.push_back({p, act, hs, vs, hc, vc});
    if (nf) begin
      m_bg = bg_req;
      m_en = en_req;
    end
    exp_pend = (bg_req != m_bg) || (en_req != m_en);
    @(posedge clk);
    #2;
  endtask

  task automatic set_idle();
    nf = 1'b0; cam = '0; y = '0; ch = '0; thr = 1'b0;
    lp = '0; lv = '0; act = 1'b0; hs = 1'b0; vs = 1'b0; hc = '0; vc = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    vectors++;
    if ({pix_o, act_o, hs_o, vs_o, hc_o, vc_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h, expected 0", {pix_o, act_o, hs_o, vs_o, hc_o, vc_o});
    end
    vectors++;
    if (pend_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_pending: got %b, expected 0", pend_o);
    end
    rst = 1'b0;
    sb_restart();
  endtask

  task automatic test_base();
    bg_req = 2'd0; en_req = '0; nf = 1'b1; act = 1'b1; cam = 24'h123456;
    step();
    set_idle();
    repeat (3) step();
    vectors++;
    if (pix_o !== 24'h000000) begin
      errors++;
      $display("FAIL base_latency_early: got %h, expected 000000", pix_o);
    end
    step();
    vectors++;
    if (pix_o !== 24'h123456) begin
      errors++;
      $display("FAIL base_latency: got %h, expected 123456", pix_o);
    end
  endtask

  task automatic test_bg_modes();
    act = 1'b1;
    bg_req = 2'd3; nf = 1'b1; thr = 1'b1; step();
    nf = 1'b0; thr = 1'b0; y = 8'h40; step();
    bg_req = 2'd2; nf = 1'b1; thr = 1'b1; step();
    nf = 1'b0; thr = 1'b0; step();
    bg_req = 2'd1; nf = 1'b1; ch = 8'h5A; step();
    nf = 1'b0;
    vectors++;
    if (pend_o !== 1'b0) begin
      errors++;
      $display("FAIL bg_pending: got %b, expected 0", pend_o);
    end
  endtask

  task automatic test_layers();
    act = 1'b1; cam = 24'h000001; bg_req = 2'd0; en_req = 4'b1111; nf = 1'b1;
    lp = {24'h444444, 24'h333333, 24'h222222, 24'h111111};
    lv = 4'b1111; step();
    nf = 1'b0;
    lv = 4'b0111; step();
    lv = 4'b0000; step();
    lv = 4'b0011; step();
    lv = 4'b1010; step();
  endtask

  task automatic test_midframe();
    act = 1'b1; bg_req = 2'd0; en_req = 4'b0000; nf = 1'b1; lv = '0;
    cam = 24'hABCDEF; ch = 8'h11; step();
    nf = 1'b0;
    bg_req = 2'd1;
    for (int i = 0; i < 4; i++) begin
      cam = 24'hABCD00 + 24'(i);
      step();
      vectors++;
      if (pend_o !== 1'b1) begin
        errors++;
        $display("FAIL midframe_pending[%0d]: got %b, expected 1", i, pend_o);
      end
    end
    nf = 1'b1; step();
    nf = 1'b0;
    vectors++;
    if (pend_o !== 1'b0) begin
      errors++;
      $display("FAIL frame_switch_pending: got %b, expected 0", pend_o);
    end
    step();
  endtask

  task automatic test_back_to_back();
    act = 1'b1; thr = 1'b1; ch = 8'h22; y = 8'h33;
    nf = 1'b1; bg_req = 2'd3; en_req = 4'b0001; lv = 4'b0000; step();
    vectors++;
    if (pend_o !== 1'b0) begin
      errors++;
      $display("FAIL b2b_first_pending: got %b, expected 0", pend_o);
    end
    bg_req = 2'd1; step();
    vectors++;
    if (pend_o !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second_pending: got %b, expected 0", pend_o);
    end
    nf = 1'b0; bg_req = 2'd2; step();
    vectors++;
    if (pend_o !== 1'b1) begin
      errors++;
      $display("FAIL b2b_after_pending: got %b, expected 1", pend_o);
    end
    bg_req = 2'd1; step();
  endtask

  task automatic test_inactive_timing();
    nf = 1'b1; bg_req = 2'd0; en_req = '0; step();
    nf = 1'b0;
    for (int i = 0; i < 12; i++) begin
      act = (i % 3) != 0;
      cam = 24'h800000 | 24'(i * 7 + 1);
      hs = (i % 4) == 1;
      vs = (i % 5) == 2;
      hc = 11'(1000 + i * 37);
      vc = 10'(700 - i * 13);
      step();
    end
  endtask

  task automatic test_reset_midstream();
    act = 1'b1; cam = 24'h777777; nf = 1'b1; bg_req = 2'd0; en_req = 4'b0100;
    hc = 11'd5; vc = 10'd9; step();
    nf = 1'b0;
    repeat (6) step();
    sb_en = 1'b0;
    rst = 1'b1;
    #1;
    vectors++;
    if ({pix_o, act_o, hs_o, vs_o, hc_o, vc_o, pend_o} !== '0) begin
      errors++;
      $display("FAIL reset_midstream: got %h, expected 0", {pix_o, act_o, hs_o, vs_o, hc_o, vc_o, pend_o});
    end
    @(posedge clk);
    #2;
    rst = 1'b0;
    sb_restart();
    set_idle();
    repeat (3) step();
    act = 1'b1; cam = 24'h0F0F0F; step();
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      nf = ($urandom_range(0, 15) == 0);
      bg_req = 2'($urandom_range(0, 3));
      en_req = 4'($urandom_range(0, 15));
      cam = 24'($urandom_range(0, 24'hFFFFFF));
      y = 8'($urandom_range(0, 255));
      ch = 8'($urandom_range(0, 255));
      thr = 1'($urandom_range(0, 1));
      for (int k = 0; k < N; k++) lp[k*PW +: PW] = 24'($urandom_range(0, 24'hFFFFFF));
      lv = 4'($urandom_range(0, 15));
      act = ($urandom_range(0, 7) != 0);
      hs = 1'($urandom_range(0, 1));
      vs = 1'($urandom_range(0, 1));
      hc = 11'($urandom_range(0, 2047));
      vc = 10'($urandom_range(0, 1023));
      step();
      vectors++;
      if (pend_o !== exp_pend) begin
        errors++;
        $display("FAIL random_pending[%0d]: got %b, expected %b", i, pend_o, exp_pend);
      end
    end
  endtask

`ifdef ALPHA_BLEND_EN
  task automatic test_alpha();
    act = 1'b1; bg_req = 2'd0; en_req = 4'b0001; nf = 1'b1;
    lp = {72'h0, 24'hFFFFFF}; lv = 4'b0001; cam = 24'h000000; step();
    nf = 1'b0; cam = 24'hFFFFFF; step();
    en_req = 4'b0011; nf = 1'b1; lp = {48'h0, 24'h246800, 24'h808080}; lv = 4'b0011; step();
    nf = 1'b0; lv = 4'b0001; cam = 24'h102030; step();
  endtask
`endif

  // watchdog so the run always ends on its own
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_base();
    set_idle();
    test_bg_modes();
    set_idle();
    test_layers();
    set_idle();
    test_midframe();
    set_idle();
    test_back_to_back();
    set_idle();
    test_inactive_timing();
    set_idle();
    test_reset_midstream();
    set_idle();
`ifdef ALPHA_BLEND_EN
    test_alpha();
    set_idle();
`endif
    test_random();
    set_idle();
    repeat (L) step();
    sb_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
